// File: rtl/goose_pkg.sv
// Goose runner shared types and constants.
// Imported by the game sequencer, its interface and sprite drawers.
package goose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    localparam int SCORE_W_DEF = 16;

    localparam logic [11:0] COL_GOOSE = 12'hFFF;
    localparam logic [11:0] COL_BEAN  = 12'h840;
    localparam logic [11:0] COL_SCORE = 12'h0F0;
    localparam logic [11:0] COL_HIT   = 12'hF00;
    localparam logic [11:0] COL_BG    = 12'h000;

endpackage

// File: rtl/game_ctrl_if.sv
// Sequencer-facing signal bundle: frame/button/collide in,
// run/jump/hit/score status out.
interface game_ctrl_if
    import goose_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               frame_tick;
    logic               btn_raw;
    logic               collide;
    logic               run_en;
    logic               jump;
    logic               hit;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_hi;
    logic [1:0]         state;

    modport master (
        output frame_tick, btn_raw, collide,
        input  run_en, jump, hit, game_over,
        input  score, score_hi, state
    );

    modport slave (
        input  frame_tick, btn_raw, collide,
        output run_en, jump, hit, game_over,
        output score, score_hi, state
    );
endinterface

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchroniser, frame-sampled
// debounce and a one-clock pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_edge
);
    localparam int CW = $clog2(DEB_FRAMES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          edge_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            edge_q  <= 1'b0;
            // any sample agreeing with the held level restarts the run
            if (frame_tick) begin
                if (sync_q2 == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEB_FRAMES - 1)) begin
                    cnt_q   <= '0;
                    level_q <= sync_q2;
                    edge_q  <= sync_q2;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign btn_level = level_q;
    assign btn_edge  = edge_q;
endmodule

// File: rtl/game_ctrl.sv
// Run/hit/game-over sequencer: owns score, high score and
// the frame counters; gates animation and issues jumps.
module game_ctrl
    import goose_pkg::*;
#(
    parameter int SCORE_W        = SCORE_W_DEF,
    parameter int SCORE_DIV      = 10,
    parameter int HIT_FRAMES     = 30,
    parameter int HOLDOFF_FRAMES = 60,
    parameter int DEB_FRAMES     = 2
) (
    input logic        clk,
    input logic        reset,
    game_ctrl_if.slave bus
);
    localparam int FW = $clog2(SCORE_DIV + 1);
    localparam int HW = $clog2(HIT_FRAMES + 1);
    localparam int OW = $clog2(HOLDOFF_FRAMES + 1);

    state_e             state_q, state_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [OW-1:0]      hold_q, hold_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               jump_q, jump_d;
    logic               btn_edge;
    logic               btn_level_unused;

    btn_debounce #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_btn (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(bus.frame_tick),
        .btn_raw   (bus.btn_raw),
        .btn_level (btn_level_unused),
        .btn_edge  (btn_edge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            hcnt_q  <= '0;
            hold_q  <= '0;
            score_q <= '0;
            hi_q    <= '0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hcnt_q  <= hcnt_d;
            hold_q  <= hold_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            jump_q  <= jump_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hcnt_d  = hcnt_q;
        hold_d  = hold_q;
        score_d = score_q;
        hi_d    = hi_q;
        jump_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                score_d = '0;
                if (btn_edge) begin
                    state_d = ST_RUN;
                    frame_d = '0;
                end
            end
            ST_RUN: begin
                // a hit swallows any jump or score tick in the same clk
                if (bus.collide) begin
                    state_d = ST_HIT;
                    hcnt_d  = '0;
                end else begin
                    jump_d = btn_edge;
                    if (bus.frame_tick) begin
                        if (frame_q == FW'(SCORE_DIV - 1)) begin
                            frame_d = '0;
                            if (score_q != '1)
                                score_d = score_q + SCORE_W'(1);
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
            end
            ST_HIT: begin
                if (score_q > hi_q)
                    hi_d = score_q;
                if (bus.frame_tick) begin
                    if (hcnt_q == HW'(HIT_FRAMES - 1)) begin
                        state_d = ST_OVER;
                        hold_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (bus.frame_tick &&
                    hold_q != OW'(HOLDOFF_FRAMES))
                    hold_d = hold_q + OW'(1);
                if (btn_edge &&
                    hold_q == OW'(HOLDOFF_FRAMES)) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    frame_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.run_en    = (state_q == ST_RUN);
    assign bus.hit       = (state_q == ST_HIT) ||
                           (state_q == ST_OVER);
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.jump      = jump_q;
    assign bus.score     = score_q;
    assign bus.score_hi  = hi_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed presses, hits and
// resets; status snapshots and jump pulses checked by a monitor.
module tb_game_ctrl;
    logic clk;
    logic reset;

    game_ctrl_if #(.SCORE_W(4)) bus ();

    game_ctrl #(
        .SCORE_W       (4),
        .SCORE_DIV     (3),
        .HIT_FRAMES    (4),
        .HOLDOFF_FRAMES(5),
        .DEB_FRAMES    (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] hi;
    } snap_t;

    snap_t sq[$];
    string jq[$];
    int    passed = 0;
    int    total  = 0;
    snap_t e;
    string jn;
    logic  x_run, x_hit, x_go;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.frame_tick = 1'b0;
        forever begin
            repeat (19) @(posedge clk);
            #1 bus.frame_tick = 1'b1;
            @(posedge clk);
            #1 bus.frame_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(negedge clk);
            while (sq.size() > 0) begin
                e = sq.pop_front();
                x_run = (e.st == 2'd1);
                x_hit = e.st[1];
                x_go = (e.st == 2'd3);
                total++;
                if (bus.state === e.st && bus.score === e.sc &&
                    bus.score_hi === e.hi &&
                    bus.run_en === x_run && bus.hit === x_hit &&
                    bus.game_over === x_go)
                    passed++;
                else
                    $display({"FAIL %s: got st=%0d sc=%0d hi=%0d",
                              " run=%b hit=%b go=%b; want st=%0d",
                              " sc=%0d hi=%0d run=%b hit=%b go=%b"},
                             e.name, bus.state, bus.score,
                             bus.score_hi, bus.run_en, bus.hit,
                             bus.game_over, e.st, e.sc, e.hi,
                             x_run, x_hit, x_go);
            end
            if (bus.jump === 1'b1) begin
                total++;
                if (jq.size() == 0) begin
                    $display("FAIL jump: got pulse st=%0d, want none",
                             bus.state);
                end else begin
                    jn = jq.pop_front();
                    if (bus.state === 2'd1)
                        passed++;
                    else
                        $display("FAIL %s: got st=%0d, want 1",
                                 jn, bus.state);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (bus.frame_tick !== 1'b1);
        end
        #2;
    endtask

    task automatic snap(input string n, input logic [1:0] st,
                        input logic [3:0] sc, input logic [3:0] hi);
        sq.push_back('{n, st, sc, hi});
        @(negedge clk);
        #1;
    endtask

    task automatic press_on();
        bus.btn_raw = 1'b1;
        tick_wait(2);
        clks(3);
    endtask

    task automatic release_btn();
        bus.btn_raw = 1'b0;
        tick_wait(2);
        clks(3);
    endtask

    task automatic collide_pulse();
        bus.collide = 1'b1;
        @(posedge clk);
        #1 bus.collide = 1'b0;
    endtask

    task automatic collide_on_tick();
        @(posedge bus.frame_tick);
        bus.collide = 1'b1;
        @(posedge clk);
        #1 bus.collide = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.btn_raw = 1'b0;
        bus.collide = 1'b0;
        clks(3);
        snap("reset_hold", 2'd0, 4'd0, 4'd0);
        reset = 1'b1;
        clks(2);
        snap("idle", 2'd0, 4'd0, 4'd0);

        tick_wait(1);
        bus.btn_raw = 1'b1;
        tick_wait(1);
        bus.btn_raw = 1'b0;
        tick_wait(2);
        snap("glitch", 2'd0, 4'd0, 4'd0);

        press_on();
        snap("start", 2'd1, 4'd0, 4'd0);
        release_btn();
        tick_wait(7);
        snap("run9", 2'd1, 4'd3, 4'd0);

        tick_wait(8);
        collide_on_tick();
        clks(2);
        snap("hit_on_tick", 2'd2, 4'd5, 4'd5);
        tick_wait(3);
        snap("hit_hold", 2'd2, 4'd5, 4'd5);
        tick_wait(1);
        snap("over", 2'd3, 4'd5, 4'd5);
        bus.collide = 1'b1;
        clks(2);
        bus.collide = 1'b0;
        snap("over_collide", 2'd3, 4'd5, 4'd5);

        press_on();
        snap("holdoff_press", 2'd3, 4'd5, 4'd5);
        release_btn();
        tick_wait(1);
        press_on();
        snap("restart", 2'd1, 4'd0, 4'd5);
        release_btn();

        jq.push_back("jump1");
        press_on();
        release_btn();
        jq.push_back("jump2");
        press_on();
        release_btn();
        snap("jumps", 2'd1, 4'd3, 4'd5);
        collide_pulse();
        clks(2);
        snap("hit_low", 2'd2, 4'd3, 4'd5);

        tick_wait(9);
        press_on();
        snap("restart2", 2'd1, 4'd0, 4'd5);
        release_btn();
        tick_wait(42);
        snap("score14", 2'd1, 4'd14, 4'd5);
        tick_wait(1);
        snap("score_max", 2'd1, 4'd15, 4'd5);
        tick_wait(6);
        snap("score_sat", 2'd1, 4'd15, 4'd5);
        collide_pulse();
        clks(2);
        snap("hit_sat", 2'd2, 4'd15, 4'd15);

        tick_wait(9);
        press_on();
        snap("restart3", 2'd1, 4'd0, 4'd15);
        release_btn();
        tick_wait(19);
        snap("pre_reset", 2'd1, 4'd7, 4'd15);
        @(posedge clk);
        #1 reset = 1'b0;
        snap("reset_mid", 2'd0, 4'd0, 4'd0);
        clks(2);
        reset = 1'b1;
        clks(2);
        bus.collide = 1'b1;
        clks(2);
        bus.collide = 1'b0;
        snap("idle_collide", 2'd0, 4'd0, 4'd0);
        clks(2);

        total++;
        if (jq.size() == 0 && sq.size() == 0)
            passed++;
        else
            $display("FAIL drain: got %0d jumps %0d snaps left, want 0 0",
                     jq.size(), sq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
